// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and address helpers for the parametrised register file
// Purpose: default geometry plus address-qualification helpers used by the
//          storage write decode and by each read port.
// Contents: DEF_WIDTH, DEF_DEPTH, addr_valid(), is_zero_reg()
package rf_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 32;

   // Only meaningful when DEPTH is not a power of two; otherwise every
   // encodable address is valid.
   function automatic logic addr_valid(input int unsigned addr, input int unsigned depth);
      return addr < depth;
   endfunction

   function automatic logic is_zero_reg(input int unsigned addr, input int unsigned zero_reg);
      return (zero_reg != 0) && (addr == 0);
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port with zero/invalid handling and bypass
// Purpose: resolves one read address against the stored array and the two
//          in-flight write lanes.
// Ports:
//   reset          - synchronous reset level; suppresses bypass while high
//   addr           - read address
//   regs           - view of the stored array
//   w0/wn0/wd0     - write lane 0 (enable, address, data)
//   w1/wn1/wd1     - write lane 1 (enable, address, data)
//   data           - read data (combinational)
module rf_read_port
   import rf_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic                         reset,
   input  logic [AW-1:0]                addr,
   input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
   input  logic                         w0,
   input  logic [AW-1:0]                wn0,
   input  logic [WIDTH-1:0]             wd0,
   input  logic                         w1,
   input  logic [AW-1:0]                wn1,
   input  logic [WIDTH-1:0]             wd1,
   output logic [WIDTH-1:0]             data
);

   always_comb begin
      data = '0;
      // Zero register and out-of-range addresses read 0 and never see bypass.
      if (!is_zero_reg(32'(addr), ZERO_REG) && addr_valid(32'(addr), DEPTH)) begin
         data = regs[addr];
         if ((BYPASS != 0) && !reset) begin
            // Lane 1 is checked first so it wins a same-address collision,
            // matching what the array will hold after the edge.
            if (w1 && (wn1 == addr)) begin
               data = wd1;
            end else if (w0 && (wn0 == addr)) begin
               data = wd0;
            end
         end
      end
   end

endmodule

// File: rtl/rf_param.sv
// rtl/rf_param.sv - parametrised two-read / two-write register file with bypass and clear
// Purpose: decode-stage register file; stores DEPTH x WIDTH flops, takes
//          write-back from two retire lanes (lane 1 has priority) and feeds
//          two combinational operand reads.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high; clears every register
//   rn1/rd1    - read port 1 address / data
//   rn2/rd2    - read port 2 address / data
//   wn0/wd0/w0 - write lane 0 address / data / enable
//   wn1/wd1/w1 - write lane 1 address / data / enable
module rf_param
   import rf_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    rn1,
   input  logic [AW-1:0]    rn2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic [AW-1:0]    wn0,
   input  logic [WIDTH-1:0] wd0,
   input  logic             w0,
   input  logic [AW-1:0]    wn1,
   input  logic [WIDTH-1:0] wd1,
   input  logic             w1
);

   logic [DEPTH-1:0][WIDTH-1:0] regs;

   // Per-entry decode: each register independently picks lane 1, then lane 0.
   // Addresses >= DEPTH match no entry, so those writes fall away naturally,
   // and a lane-1 write to a hardwired zero register cannot mask a lane-0
   // write to a different entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         regs <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!is_zero_reg(i, ZERO_REG)) begin
               if (w1 && (wn1 == AW'(i))) begin
                  regs[i] <= wd1;
               end else if (w0 && (wn0 == AW'(i))) begin
                  regs[i] <= wd0;
               end
            end
         end
      end
   end

   rf_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
   ) u_read1 (
      .reset (reset),
      .addr  (rn1),
      .regs  (regs),
      .w0    (w0),
      .wn0   (wn0),
      .wd0   (wd0),
      .w1    (w1),
      .wn1   (wn1),
      .wd1   (wd1),
      .data  (rd1)
   );

   rf_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
   ) u_read2 (
      .reset (reset),
      .addr  (rn2),
      .regs  (regs),
      .w0    (w0),
      .wn0   (wn0),
      .wd0   (wd0),
      .w1    (w1),
      .wn1   (wn1),
      .wd1   (wd1),
      .data  (rd2)
   );

endmodule
